mul_iter: RTL and testbench

MUL_ITER -- requirements
Module: mul_iter

---
 rtl/mul_iter.sv | 160 ++++++++++++++++
 tb/tb_mul_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_iter
//  Brief    : Iterative radix-2 shift-add 32x32 -> 64-bit multiplier.
//             Signed operands are reduced to magnitudes at the start edge.
//             The magnitudes are multiplied over 32 CALC cycles. The sign is
//             re-applied when the final step writes the result register.
//  Revision : 1.0 - initial release
// ============================================================================
module mul_iter (
   input  logic        mul_clk,
   input  logic        reset,
   input  logic        mul,
   input  logic        mul_signed,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [63:0] result,
   output logic        complete
);

   // FSM encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] C_LAST_STEP = 5'd31;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;

   logic [4:0]  r_count;
   logic [31:0] r_abs_x;
   logic [31:0] r_abs_y;
   logic        r_neg;
   logic [63:0] r_acc;
   logic [63:0] r_result;

   logic        w_start;
   logic        w_step;
   logic        w_last;
   logic [31:0] w_abs_x;
   logic [31:0] w_abs_y;
   logic        w_neg;
   logic [63:0] w_partial;
   logic [63:0] w_acc_sum;

   // Qualified events derived from the current state and the request line.
   // A step only happens while the requester keeps mul high; dropping it
   // in CALC is an abort and must not touch the accumulator or result.
   always_comb begin
      w_start = (r_state == S_IDLE) && mul;
      w_step  = (r_state == S_CALC) && mul;
      w_last  = w_step && (r_count == C_LAST_STEP);
   end

   // Operand magnitudes and product sign, evaluated on the live inputs and
   // captured only at the start edge. 0x80000000 negates to itself, which
   // read as unsigned is exactly 2^31, so no special case is needed.
   always_comb begin
      w_abs_x = (mul_signed && x[31]) ? (~x + 32'd1) : x;
      w_abs_y = (mul_signed && y[31]) ? (~y + 32'd1) : y;
      w_neg   = mul_signed && (x[31] ^ y[31]);
   end

   // One shift-add step: add abs_x << count when multiplier bit[count] set.
   always_comb begin
      w_partial = r_abs_y[r_count] ? ({32'd0, r_abs_x} << r_count) : 64'd0;
      w_acc_sum = r_acc + w_partial;
   end

   // State register
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; DONE always returns to IDLE so mul is re-sampled
   // only from IDLE (no back-to-back start).
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (mul) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            if (!mul) begin
               w_state_next = S_IDLE;
            end else if (r_count == C_LAST_STEP) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode: complete is a pure function of the state register.
   always_comb begin
      complete = (r_state == S_DONE);
   end

   // Operand capture; held constant for the whole CALC phase so input
   // changes after the start edge cannot disturb the in-flight product.
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         r_abs_x <= 32'd0;
         r_abs_y <= 32'd0;
         r_neg   <= 1'b0;
      end else if (w_start) begin
         r_abs_x <= w_abs_x;
         r_abs_y <= w_abs_y;
         r_neg   <= w_neg;
      end
   end

   // Step counter: cleared on start, advanced once per CALC step.
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         r_count <= 5'd0;
      end else if (w_start) begin
         r_count <= 5'd0;
      end else if (w_step) begin
         r_count <= r_count + 5'd1;
      end
   end

   // 64-bit accumulator: cleared on start, one partial product per step.
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         r_acc <= 64'd0;
      end else if (w_start) begin
         r_acc <= 64'd0;
      end else if (w_step) begin
         r_acc <= w_acc_sum;
      end
   end

   // Result register: written only on the final step (DONE entry) with the
   // sign re-applied; a zero magnitude negates to zero, so no negative zero.
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         r_result <= 64'd0;
      end else if (w_last) begin
         r_result <= r_neg ? (~w_acc_sum + 64'd1) : w_acc_sum;
      end
   end

   assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_iter
//  Brief    : Self-checking bench for mul_iter. The reference is a
//             behavioural model that tracks request timing and computes
//             products with plain 64-bit arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_iter;

   logic        mul_clk;
   logic        reset;
   logic        mul;
   logic        mul_signed;
   logic [31:0] x;
   logic [31:0] y;
   logic [63:0] result;
   logic        complete;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   int          m_phase   = 0;     // 0 idle, 1..32 calc cycles elapsed, 33 done
   logic [63:0] m_pending = 64'd0;
   logic [63:0] m_result  = 64'd0;
   logic        m_complete;

   mul_iter dut (
      .mul_clk    (mul_clk),
      .reset      (reset),
      .mul        (mul),
      .mul_signed (mul_signed),
      .x          (x),
      .y          (y),
      .result     (result),
      .complete   (complete)
   );

   initial mul_clk = 1'b0;
   always #5 mul_clk = ~mul_clk;

   // Reference product: sign- or zero-extend to 64 bits and multiply modulo 2^64.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = s ? {{32{a[31]}}, a} : {32'd0, a};
      eb = s ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
   endfunction

   // Timing model: start in idle, 32 calc edges, one done cycle, abort on mul low.
   always @(posedge mul_clk) begin
      if (reset) begin
         m_phase  = 0;
         m_result = 64'd0;
      end else if (m_phase == 0) begin
         if (mul) begin
            m_pending = ref_mul(x, y, mul_signed);
            m_phase   = 1;
         end
      end else if (m_phase == 33) begin
         m_phase = 0;
      end else begin
         if (!mul) begin
            m_phase = 0;
         end else if (m_phase == 32) begin
            m_result = m_pending;
            m_phase  = 33;
         end else begin
            m_phase = m_phase + 1;
         end
      end
      m_complete = (m_phase == 33);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle and compare the DUT against the model away from the edge.
   task automatic tick();
      @(negedge mul_clk);
      check("complete", {63'd0, complete}, {63'd0, m_complete});
      check("result", result, m_result);
   endtask

   // Run one request. scramble_at: cycle at which operands are randomised
   // (0 = never). abort_at: cycle after which mul is dropped (0 = never).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int scramble_at, input int abort_at, output int lat);
      bit done;
      bit aborted;
      done    = 1'b0;
      aborted = 1'b0;
      lat     = 0;
      x = a; y = b; mul_signed = s; mul = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         lat = i;
         if (complete) begin
            done = 1'b1;
            break;
         end
         if (i == scramble_at) begin
            x = $urandom; y = $urandom; mul_signed = 1'($urandom_range(0, 1));
         end
         if (i == abort_at) begin
            mul     = 1'b0;
            aborted = 1'b1;
            break;
         end
      end
      mul = 1'b0;
      if (!done && !aborted) begin
         check("timeout_waiting_complete", 64'd0, 64'd1);
      end
      if (!aborted) begin
         check("latency", 64'(lat), 64'd33);
      end
      tick();
      if (aborted) tick();
   endtask

   int lat;

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1; mul = 1'b1; mul_signed = 1'b0; x = 32'd7; y = 32'd9;
      tick();
      check("reset_result", result, 64'd0);
      check("reset_complete", {63'd0, complete}, 64'd0);

      // Pin the reference model with hand-computed products.
      check("model_u_7x9", ref_mul(32'd7, 32'd9, 1'b0), 64'h0000_0000_0000_003F);
      check("model_u_max", ref_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
      check("model_s_m3x5", ref_mul(32'hFFFF_FFFD, 32'd5, 1'b1), 64'hFFFF_FFFF_FFFF_FFF1);
      check("model_s_min_min", ref_mul(32'h8000_0000, 32'h8000_0000, 1'b1), 64'h4000_0000_0000_0000);

      // Release reset with mul already high: that edge starts the op.
      reset = 1'b0;
      do_op(32'd7, 32'd9, 1'b0, 0, 0, lat);
      check("lit_7x9", result, 64'h0000_0000_0000_003F);
      check("lit_7x9_complete_low", {63'd0, complete}, 64'd0);

      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, lat);
      check("lit_u_max", result, 64'hFFFF_FFFE_0000_0001);
      do_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, lat);
      check("lit_s_m3x5", result, 64'hFFFF_FFFF_FFFF_FFF1);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0, lat);
      check("lit_s_m1xm1", result, 64'd1);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, lat);
      check("lit_s_min_min", result, 64'h4000_0000_0000_0000);
      do_op(32'h8000_0000, 32'd1, 1'b1, 0, 0, lat);
      check("lit_s_min_x1", result, 64'hFFFF_FFFF_8000_0000);
      do_op(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 0, 0, lat);
      check("lit_s_zero", result, 64'd0);

      // Complete 7*9, then abort a 3*3 mid-calculation: result must hold.
      do_op(32'd7, 32'd9, 1'b0, 0, 0, lat);
      do_op(32'd3, 32'd3, 1'b0, 0, 10, lat);
      check("lit_abort_hold", result, 64'h0000_0000_0000_003F);

      // Operand change mid-calculation must not affect the latched product.
      do_op(32'd12345, 32'hFFFF_0001, 1'b1, 5, 0, lat);
      check("lit_scramble", result, ref_mul(32'd12345, 32'hFFFF_0001, 1'b1));

      // Reset mid-calculation, then a fresh 2*3.
      x = 32'd5; y = 32'd5; mul_signed = 1'b0; mul = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      reset = 1'b1;
      tick();
      check("lit_reset_mid_result", result, 64'd0);
      check("lit_reset_mid_complete", {63'd0, complete}, 64'd0);
      reset = 1'b0; mul = 1'b0;
      tick();
      do_op(32'd2, 32'd3, 1'b0, 0, 0, lat);
      check("lit_2x3", result, 64'd6);

      // Randomised operations, some with mid-flight operand changes or aborts.
      for (int n = 0; n < 24; n++) begin
         int sc;
         int ab;
         sc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32)) : 0;
         do_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), sc, ab, lat);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
